recompute_merge_unit: RTL and testbench

- Sits at the bottom edge of the weight-stationary systolic array, downstream of recompute_unit.
- Consumes recompute_unit's corrected product (BottomOut) and its one-hot fault tags (faultyRowOut, faultyColOut).
- Adds each correction into the matching column's partial-sum output, restoring the result that the bypassed faulty PE failed to contribute.
- Registers the patched column results toward the output buffer.

---
 rtl/bisr_pkg.sv | 20 ++
 rtl/merge_lane.sv | 60 ++++++
 rtl/recompute_merge_unit.sv | 66 ++++++
 tb/tb_recompute_merge_unit.sv | 187 ++++++++++++++++++
 4 files changed

// File: rtl/bisr_pkg.sv
// Shared types and constants for the recompute merge path.
// Provides lane FSM states, default geometry and a one-hot test helper.
package bisr_pkg;

   localparam int ROWS_D      = 3;
   localparam int COLS_D      = 3;
   localparam int WORD_SIZE_D = 16;
   localparam int CNT_W       = 8;

   typedef enum logic {
      IDLE = 1'b0,
      PEND = 1'b1
   } lane_state_t;

   // True when exactly one bit is set; callers zero-extend to 32 bits.
   function automatic logic is_onehot(input logic [31:0] vec);
      return (vec != '0) && ((vec & (vec - 32'd1)) == '0);
   endfunction

endpackage

// File: rtl/merge_lane.sv
// One merge lane: accumulates corrections for a column and adds them
// into that column's partial sum on the next strobe.
// Ports: corr_hit/corr_data (accepted correction for this lane),
//   strobe/psum (array column output), out_valid/out_psum (registered
//   merged result), pending (registered PEND state).
module merge_lane
   import bisr_pkg::*;
#(
   parameter int WORD_SIZE = WORD_SIZE_D
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 corr_hit,
   input  logic [WORD_SIZE-1:0] corr_data,
   input  logic                 strobe,
   input  logic [WORD_SIZE-1:0] psum,
   output logic                 out_valid,
   output logic [WORD_SIZE-1:0] out_psum,
   output logic                 pending
);

   lane_state_t          state_q;
   lane_state_t          state_d;
   logic [WORD_SIZE-1:0] acc_q;
   logic [WORD_SIZE-1:0] acc_d;
   logic [WORD_SIZE-1:0] add_corr;
   logic [WORD_SIZE-1:0] sum;

   always_comb begin
      add_corr = corr_hit ? corr_data : '0;
      // A correction arriving with the strobe joins the emerging wave.
      sum      = psum + acc_q + add_corr;
      state_d  = state_q;
      acc_d    = acc_q;
      unique case (state_q)
         IDLE:    if (corr_hit && !strobe) state_d = PEND;
         PEND:    if (strobe) state_d = IDLE;
         default: state_d = IDLE;
      endcase
      if (strobe) acc_d = '0;
      else        acc_d = acc_q + add_corr;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= IDLE;
         acc_q     <= '0;
         out_valid <= 1'b0;
         out_psum  <= '0;
      end else begin
         state_q   <= state_d;
         acc_q     <= acc_d;
         out_valid <= strobe;
         if (strobe) out_psum <= sum;
      end
   end

   assign pending = (state_q == PEND);

endmodule

// File: rtl/recompute_merge_unit.sv
// Merges recompute_unit corrections into systolic column partial sums.
// Ports: corr_valid/BottomOut/faultyRowOut/faultyColOut correction in,
//   col_valid/col_psum column sums in, out_valid/out_psum merged out,
//   corr_pending per lane, sticky tag_err, saturating corr_count.
module recompute_merge_unit
   import bisr_pkg::*;
#(
   parameter int ROWS      = ROWS_D,
   parameter int COLS      = COLS_D,
   parameter int WORD_SIZE = WORD_SIZE_D
) (
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic                      corr_valid,
   input  logic [WORD_SIZE-1:0]      BottomOut,
   input  logic [ROWS-1:0]           faultyRowOut,
   input  logic [COLS-1:0]           faultyColOut,
   input  logic [COLS-1:0]           col_valid,
   input  logic [COLS*WORD_SIZE-1:0] col_psum,
   output logic [COLS-1:0]           out_valid,
   output logic [COLS*WORD_SIZE-1:0] out_psum,
   output logic [COLS-1:0]           corr_pending,
   output logic                      tag_err,
   output logic [CNT_W-1:0]          corr_count
);

   localparam logic [CNT_W-1:0] CNT_MAX = '1;

   logic row_ok;
   logic col_ok;
   logic accept;
   logic bad_tag;

   assign row_ok  = is_onehot(32'(faultyRowOut));
   assign col_ok  = is_onehot(32'(faultyColOut));
   assign accept  = corr_valid && row_ok && col_ok;
   assign bad_tag = corr_valid && !(row_ok && col_ok);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         tag_err    <= 1'b0;
         corr_count <= '0;
      end else begin
         if (bad_tag) tag_err <= 1'b1;
         if (accept && corr_count != CNT_MAX)
            corr_count <= corr_count + 1'b1;
      end
   end

   for (genvar c = 0; c < COLS; c++) begin : g_lane
      merge_lane #(
         .WORD_SIZE (WORD_SIZE)
      ) u_lane (
         .clk       (clk),
         .rst_n     (rst_n),
         .corr_hit  (accept && faultyColOut[c]),
         .corr_data (BottomOut),
         .strobe    (col_valid[c]),
         .psum      (col_psum[c*WORD_SIZE +: WORD_SIZE]),
         .out_valid (out_valid[c]),
         .out_psum  (out_psum[c*WORD_SIZE +: WORD_SIZE]),
         .pending   (corr_pending[c])
      );
   end

endmodule

// File: tb/tb_recompute_merge_unit.sv
// Self-checking bench for recompute_merge_unit.
// Vector table plus hand sequences for tag errors, reset and saturation.
module tb_recompute_merge_unit;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        corr_valid;
   logic [15:0] BottomOut;
   logic [2:0]  faultyRowOut;
   logic [2:0]  faultyColOut;
   logic [2:0]  col_valid;
   logic [47:0] col_psum;
   logic [2:0]  out_valid;
   logic [47:0] out_psum;
   logic [2:0]  corr_pending;
   logic        tag_err;
   logic [7:0]  corr_count;

   int checks = 0;
   int errors = 0;

   typedef struct {
      logic        cv;
      logic [15:0] bo;
      logic [2:0]  row;
      logic [2:0]  col;
      logic [2:0]  cval;
      logic [47:0] psum;
      logic [2:0]  e_ov;
      logic [47:0] e_ps;
      logic [2:0]  e_pend;
      logic        e_err;
      logic [7:0]  e_cnt;
   } vec_t;

   vec_t sb[$];
   vec_t tbl[11];

   recompute_merge_unit dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .corr_valid   (corr_valid),
      .BottomOut    (BottomOut),
      .faultyRowOut (faultyRowOut),
      .faultyColOut (faultyColOut),
      .col_valid    (col_valid),
      .col_psum     (col_psum),
      .out_valid    (out_valid),
      .out_psum     (out_psum),
      .corr_pending (corr_pending),
      .tag_err      (tag_err),
      .corr_count   (corr_count)
   );

   always #5 clk = ~clk;

   function automatic vec_t mk(
      input logic cv, input logic [15:0] bo,
      input logic [2:0] row, input logic [2:0] col,
      input logic [2:0] cval, input logic [47:0] psum,
      input logic [2:0] e_ov, input logic [47:0] e_ps,
      input logic [2:0] e_pend, input logic e_err,
      input logic [7:0] e_cnt);
      vec_t v;
      v.cv = cv; v.bo = bo; v.row = row; v.col = col;
      v.cval = cval; v.psum = psum; v.e_ov = e_ov;
      v.e_ps = e_ps; v.e_pend = e_pend; v.e_err = e_err;
      v.e_cnt = e_cnt;
      return v;
   endfunction

   task automatic chk(input string name, input logic [47:0] act,
                      input logic [47:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s got %0d expected %0d", name, act, exp);
      end
   endtask

   task automatic idle_inputs();
      corr_valid   = 1'b0;
      BottomOut    = '0;
      faultyRowOut = '0;
      faultyColOut = '0;
      col_valid    = '0;
      col_psum     = '0;
   endtask

   // Drive one cycle of stimulus, then compare the registered outcome.
   task automatic step(input vec_t v, input string tag);
      vec_t e;
      corr_valid   = v.cv;
      BottomOut    = v.bo;
      faultyRowOut = v.row;
      faultyColOut = v.col;
      col_valid    = v.cval;
      col_psum     = v.psum;
      sb.push_back(v);
      @(posedge clk);
      #1;
      e = sb.pop_front();
      chk({tag, ".out_valid"}, 48'(out_valid), 48'(e.e_ov));
      for (int c = 0; c < 3; c++)
         if (e.e_ov[c])
            chk($sformatf("%s.lane%0d", tag, c),
                48'(out_psum[c*16 +: 16]), 48'(e.e_ps[c*16 +: 16]));
      chk({tag, ".pending"}, 48'(corr_pending), 48'(e.e_pend));
      chk({tag, ".tag_err"}, 48'(tag_err), 48'(e.e_err));
      chk({tag, ".count"}, 48'(corr_count), 48'(e.e_cnt));
   endtask

   task automatic do_reset();
      idle_inputs();
      rst_n = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      rst_n = 1'b1;
   endtask

   initial begin
      tbl[0]  = mk(0, 0, 0, 0, 3'b010, {16'd0, 16'd100, 16'd0},
                   3'b010, {16'd0, 16'd100, 16'd0}, 0, 0, 0);
      tbl[1]  = mk(1, 12, 3'b001, 3'b001, 0, 0, 0, 0, 3'b001, 0, 1);
      tbl[2]  = mk(0, 0, 0, 0, 0, 0, 0, 0, 3'b001, 0, 1);
      tbl[3]  = mk(0, 0, 0, 0, 3'b001, {16'd0, 16'd0, 16'd50},
                   3'b001, {16'd0, 16'd0, 16'd62}, 0, 0, 1);
      tbl[4]  = mk(1, 56, 3'b001, 3'b010, 3'b010, {16'd0, 16'd4, 16'd0},
                   3'b010, {16'd0, 16'd60, 16'd0}, 0, 0, 2);
      tbl[5]  = mk(0, 0, 0, 0, 3'b010, {16'd0, 16'd4, 16'd0},
                   3'b010, {16'd0, 16'd4, 16'd0}, 0, 0, 2);
      tbl[6]  = mk(1, 200, 3'b001, 3'b100, 0, 0, 0, 0, 3'b100, 0, 3);
      tbl[7]  = mk(1, 300, 3'b010, 3'b100, 0, 0, 0, 0, 3'b100, 0, 4);
      tbl[8]  = mk(0, 0, 0, 0, 3'b100, {16'hFFFF, 16'd0, 16'd0},
                   3'b100, {16'd499, 16'd0, 16'd0}, 0, 0, 4);
      tbl[9]  = mk(0, 999, 3'b000, 3'b011, 0, 0, 0, 0, 0, 0, 4);
      tbl[10] = mk(1, 5, 3'b100, 3'b100, 3'b111,
                   {16'd20, 16'd30, 16'd40},
                   3'b111, {16'd25, 16'd30, 16'd40}, 0, 0, 5);

      do_reset();
      chk("reset.out_valid", 48'(out_valid), 0);
      chk("reset.out_psum", out_psum, 0);
      chk("reset.pending", 48'(corr_pending), 0);
      chk("reset.tag_err", 48'(tag_err), 0);
      chk("reset.count", 48'(corr_count), 0);

      for (int i = 0; i < 11; i++)
         step(tbl[i], $sformatf("vec%0d", i));

      // Malformed tags: dropped, sticky error, no count.
      do_reset();
      step(mk(1, 9, 3'b001, 3'b011, 0, 0, 0, 0, 0, 1, 0), "bad_col");
      step(mk(1, 9, 3'b000, 3'b001, 0, 0, 0, 0, 0, 1, 0), "bad_row");
      step(mk(0, 0, 0, 0, 3'b011, {16'd0, 16'd22, 16'd11},
              3'b011, {16'd0, 16'd22, 16'd11}, 0, 1, 0), "bad_pass");
      step(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0), "bad_sticky");

      // Pending correction then asynchronous reset mid-cycle.
      step(mk(1, 7, 3'b001, 3'b001, 0, 0, 0, 0, 3'b001, 1, 1), "pre_rst");
      #2;
      rst_n = 1'b0;
      #1;
      chk("async.out_psum", out_psum, 0);
      chk("async.pending", 48'(corr_pending), 0);
      chk("async.tag_err", 48'(tag_err), 0);
      chk("async.count", 48'(corr_count), 0);
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      step(mk(0, 0, 0, 0, 3'b001, {16'd0, 16'd0, 16'd10},
              3'b001, {16'd0, 16'd0, 16'd10}, 0, 0, 0), "post_rst");

      // Counter saturation with 260 corrections accumulated on lane 0.
      for (int i = 0; i < 260; i++)
         step(mk(1, 1, 3'b010, 3'b001, 0, 0, 0, 0, 3'b001, 0,
                 8'((i + 1 > 255) ? 255 : i + 1)),
              $sformatf("sat%0d", i));
      step(mk(0, 0, 0, 0, 3'b001, 0, 3'b001, {16'd0, 16'd0, 16'd260},
              0, 0, 255), "sat_merge");

      idle_inputs();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
